// File: rtl/ysyx_041461_pipe_pkg.sv
// ysyx_041461_pipe_pkg: shared stage state encoding and per-stage payload widths
package ysyx_041461_pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} pipe_state_e;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned IF_ID_W   = XLEN + 32;
  localparam int unsigned ID_EXE_W  = 3 * XLEN + 32 + 16;
  localparam int unsigned EXE_MEM_W = 2 * XLEN + 32 + 16;
  localparam int unsigned MEM_WB_W  = XLEN + 32 + 8;
  function automatic logic pipe_ready(pipe_state_e s);
    return s != FULL;
  endfunction
endpackage

// File: rtl/ysyx_041461_pipe_slot.sv
// ysyx_041461_pipe_slot: one payload register with load enable and reset value
module ysyx_041461_pipe_slot #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W-1:0] data_q;
  // capture the payload only when loaded; reset restores the instance default
  always_ff @(posedge clk or negedge rst)
    if (!rst) data_q <= RESET_DATA;
    else if (ld_i) data_q <= d_i;
  assign q_o = data_q;
endmodule

// File: rtl/ysyx_041461_pipe_stage.sv
// ysyx_041461_pipe_stage: elastic valid/ready pipeline register with optional skid entry
module ysyx_041461_pipe_stage
  import ysyx_041461_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);
  pipe_state_e       state_q, state_d;
  logic              rdy_q, acc, drn, ld_m, m_from_s;
  logic [DATA_W-1:0] m_d, s_q;
  assign out_valid = state_q != EMPTY;
  assign count     = state_q;
  assign in_ready  = SKID ? rdy_q : (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;
  assign m_d       = m_from_s ? s_q : in_data;
  // next state and main-slot load; flush wins over any accept or drain
  always_comb begin
    state_d  = state_q;
    ld_m     = 1'b0;
    m_from_s = 1'b0;
    if (flush) state_d = EMPTY;
    else if (state_q == EMPTY) begin
      ld_m    = acc;
      state_d = acc ? ONE : EMPTY;
    end else if (state_q == ONE) begin
      ld_m    = acc && drn;
      state_d = (acc && !drn && SKID) ? FULL : (!acc && drn) ? EMPTY : ONE;
    end else if (drn) begin
      ld_m     = 1'b1;
      m_from_s = 1'b1;
      state_d  = ONE;
    end
  end
  // occupancy state plus in_ready precomputed from the next state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= pipe_ready(state_d);
    end
  ysyx_041461_pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_m (
    .clk(clk), .rst(rst), .ld_i(ld_m), .d_i(m_d), .q_o(out_data)
  );
  if (SKID) begin : g_skid
    logic ld_s;
    assign ld_s = !flush && state_q == ONE && acc && !drn;
    ysyx_041461_pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_s (
      .clk(clk), .rst(rst), .ld_i(ld_s), .d_i(in_data), .q_o(s_q)
    );
  end else begin : g_noskid
    assign s_q = RESET_DATA;
  end
endmodule

// File: tb/tb_ysyx_041461_pipe_stage.sv
// tb_ysyx_041461_pipe_stage: directed and random checks of skid and non-skid stages
module tb_ysyx_041461_pipe_stage;
  localparam logic [63:0] RD1 = 64'h0000_0000_3000_0000;
  localparam logic [15:0] RD0 = 16'hBEEF;
  logic clk = 1'b0, rst = 1'b1;
  logic fl1 = 1'b0, v1 = 1'b0, or1 = 1'b0, ir1, ov1;
  logic [63:0] d1 = '0, od1;
  logic [1:0] c1;
  logic fl0 = 1'b0, v0 = 1'b0, or0 = 1'b0, ir0, ov0;
  logic [15:0] d0 = '0, od0;
  logic [1:0] c0;
  int tests = 0, fails = 0;
  logic [63:0] q1[$];
  logic [15:0] q0[$];
  bit acc1, acc0;

  always #5 clk = ~clk;

  ysyx_041461_pipe_stage #(.DATA_W(64), .RESET_DATA(RD1), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(v1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(c1)
  );
  ysyx_041461_pipe_stage #(.DATA_W(16), .RESET_DATA(RD0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(v0), .in_ready(ir0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .count(c0)
  );

  // one clock of the reference: a FIFO of held entries, depth 2 with skid, 1 without
  task automatic step();
    bit a1, r1, f1, a0, r0, f0;
    logic [63:0] x1;
    logic [15:0] x0;
    a1 = v1 && q1.size() < 2;  r1 = or1 && q1.size() > 0;  f1 = fl1; x1 = d1;
    a0 = v0 && (q0.size() == 0 || or0); r0 = or0 && q0.size() > 0; f0 = fl0; x0 = d0;
    @(posedge clk);
    if (f1) q1.delete();
    else begin
      if (r1) void'(q1.pop_front());
      if (a1) q1.push_back(x1);
    end
    if (f0) q0.delete();
    else begin
      if (r0) void'(q0.pop_front());
      if (a0) q0.push_back(x0);
    end
    acc1 = a1 && !f1;
    acc0 = a0 && !f0;
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL rst_ov1 got %h exp 0", ov1); end
    tests++; if (c1 !== 2'd0) begin fails++; $display("FAIL rst_c1 got %0d exp 0", c1); end
    tests++; if (od1 !== RD1) begin fails++; $display("FAIL rst_od1 got %h exp %h", od1, RD1); end
    tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL rst_ir1 got %h exp 1", ir1); end
    tests++; if (od0 !== RD0) begin fails++; $display("FAIL rst_od0 got %h exp %h", od0, RD0); end
    tests++; if (ir0 !== 1'b1) begin fails++; $display("FAIL rst_ir0 got %h exp 1", ir0); end
    @(negedge clk); rst = 1'b1; v1 = 1'b1; d1 = 64'h77;
    step();
    tests++; if (od1 !== 64'h77 || ov1 !== 1'b1) begin fails++; $display("FAIL rst_first got %h/%h exp 77/1", od1, ov1); end
    d1 = 64'h78;
    step();
    v1 = 1'b0;
    tests++; if (c1 !== 2'd2) begin fails++; $display("FAIL rst_fill got %0d exp 2", c1); end
    @(negedge clk); rst = 1'b0; #1;
    q1.delete(); q0.delete();
    tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL midrst_ov got %h exp 0", ov1); end
    tests++; if (c1 !== 2'd0) begin fails++; $display("FAIL midrst_c got %0d exp 0", c1); end
    tests++; if (od1 !== RD1) begin fails++; $display("FAIL midrst_od got %h exp %h", od1, RD1); end
    tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL midrst_ir got %h exp 1", ir1); end
    @(negedge clk); rst = 1'b1; v1 = 1'b1; d1 = 64'h99;
    step();
    v1 = 1'b0;
    tests++; if (od1 !== 64'h99 || ov1 !== 1'b1) begin fails++; $display("FAIL midrst_first got %h/%h exp 99/1", od1, ov1); end
    or1 = 1'b1;
    step();
    tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL rst_drain got %h exp 0", ov1); end
  endtask

  task automatic test_streaming();
    or1 = 1'b1; v1 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      d1 = 64'(i);
      step();
      tests++; if (ov1 !== 1'b1 || od1 !== 64'(i)) begin fails++; $display("FAIL stream_%0d got %h/%h exp 1/%h", i, ov1, od1, i); end
      tests++; if (c1 !== 2'd1 || ir1 !== 1'b1) begin fails++; $display("FAIL stream_cnt_%0d got %0d/%h exp 1/1", i, c1, ir1); end
    end
    v1 = 1'b0;
    step();
    tests++; if (ov1 !== 1'b0 || c1 !== 2'd0) begin fails++; $display("FAIL stream_end got %h/%0d exp 0/0", ov1, c1); end
  endtask

  task automatic test_back_pressure();
    or1 = 1'b0; v1 = 1'b1; d1 = 64'hA;
    step();
    d1 = 64'hB;
    step();
    tests++; if (c1 !== 2'd2) begin fails++; $display("FAIL bp_count got %0d exp 2", c1); end
    tests++; if (ir1 !== 1'b0) begin fails++; $display("FAIL bp_ready got %h exp 0", ir1); end
    d1 = 64'hC;
    step();
    tests++; if (c1 !== 2'd2 || od1 !== 64'hA) begin fails++; $display("FAIL bp_hold got %0d/%h exp 2/a", c1, od1); end
    or1 = 1'b1;
    step();
    tests++; if (od1 !== 64'hB || c1 !== 2'd1) begin fails++; $display("FAIL bp_out_b got %h/%0d exp b/1", od1, c1); end
    tests++; if (acc1 !== 1'b0 || ir1 !== 1'b1) begin fails++; $display("FAIL bp_c_wait got %h/%h exp 0/1", acc1, ir1); end
    step();
    tests++; if (od1 !== 64'hC || c1 !== 2'd1) begin fails++; $display("FAIL bp_out_c got %h/%0d exp c/1", od1, c1); end
    v1 = 1'b0;
    step();
    tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL bp_end got %h exp 0", ov1); end
  endtask

  task automatic test_flush();
    or1 = 1'b0; v1 = 1'b1; d1 = 64'h11;
    step();
    d1 = 64'h22;
    step();
    tests++; if (c1 !== 2'd2) begin fails++; $display("FAIL fl_fill got %0d exp 2", c1); end
    fl1 = 1'b1; d1 = 64'h33;
    step();
    fl1 = 1'b0; v1 = 1'b0;
    tests++; if (ov1 !== 1'b0 || c1 !== 2'd0) begin fails++; $display("FAIL fl_empty got %h/%0d exp 0/0", ov1, c1); end
    tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL fl_ready got %h exp 1", ir1); end
    tests++; if (od1 !== 64'h11) begin fails++; $display("FAIL fl_keep got %h exp 11", od1); end
    or1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL fl_no33_%0d got %h/%h exp 0", i, ov1, od1); end
    end
  endtask

  task automatic test_noskid();
    or0 = 1'b0; v0 = 1'b1; d0 = 16'd5;
    step();
    tests++; if (od0 !== 16'd5 || c0 !== 2'd1) begin fails++; $display("FAIL ns_m5 got %h/%0d exp 5/1", od0, c0); end
    #1;
    tests++; if (ir0 !== 1'b0) begin fails++; $display("FAIL ns_stall got %h exp 0", ir0); end
    or0 = 1'b1; d0 = 16'd6; #1;
    tests++; if (ir0 !== 1'b1) begin fails++; $display("FAIL ns_comb got %h exp 1", ir0); end
    step();
    tests++; if (od0 !== 16'd6 || c0 !== 2'd1 || ov0 !== 1'b1) begin fails++; $display("FAIL ns_m6 got %h/%0d exp 6/1", od0, c0); end
    v0 = 1'b0;
    step();
    tests++; if (ov0 !== 1'b0 || c0 !== 2'd0) begin fails++; $display("FAIL ns_end got %h/%0d exp 0/0", ov0, c0); end
  endtask

  task automatic test_soak();
    int n1 = 1000, n0 = 1000;
    for (int k = 0; k < 3000; k++) begin
      if (!(v1 && !acc1 && !fl1)) begin v1 = $urandom_range(0, 3) != 0; d1 = {32'($urandom), 32'(n1)}; n1++; end
      if (!(v0 && !acc0 && !fl0)) begin v0 = $urandom_range(0, 3) != 0; d0 = 16'(n0); n0++; end
      fl1 = $urandom_range(0, 15) == 0; or1 = $urandom_range(0, 2) != 0;
      fl0 = $urandom_range(0, 15) == 0; or0 = $urandom_range(0, 2) != 0;
      #1;
      tests++; if (ir1 !== (q1.size() < 2)) begin fails++; $display("FAIL soak_ir1 @%0d got %h", k, ir1); end
      tests++; if (ir0 !== (q0.size() == 0 || or0)) begin fails++; $display("FAIL soak_ir0 @%0d got %h", k, ir0); end
      step();
      tests++; if (ov1 !== (q1.size() > 0) || c1 !== 2'(q1.size())) begin fails++; $display("FAIL soak_c1 @%0d got %h/%0d exp %0d", k, ov1, c1, q1.size()); end
      tests++; if (ov0 !== (q0.size() > 0) || c0 !== 2'(q0.size())) begin fails++; $display("FAIL soak_c0 @%0d got %h/%0d exp %0d", k, ov0, c0, q0.size()); end
      if (q1.size() > 0) begin
        tests++; if (od1 !== q1[0]) begin fails++; $display("FAIL soak_od1 @%0d got %h exp %h", k, od1, q1[0]); end
      end
      if (q0.size() > 0) begin
        tests++; if (od0 !== q0[0]) begin fails++; $display("FAIL soak_od0 @%0d got %h exp %h", k, od0, q0[0]); end
      end
    end
    v1 = 1'b0; v0 = 1'b0; fl1 = 1'b0; fl0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_noskid();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_041461_pipe_stage.md
# ysyx_041461_pipe_stage

Parametrised, elastic inter-stage pipeline register that replaces the fixed-field, enable-gated stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries an opaque DATA_W-bit payload under a valid/ready handshake, supports a synchronous flush from the control/hazard unit, and optionally adds a skid entry so that `in_ready` is registered and throughput stays at one transfer per cycle. One instance sits between each pair of pipeline stages. The producer packs its control fields into `in_data`; the consumer unpacks them from `out_data`.

## Interface
- `DATA_W`, default 64: payload width in bits, legal range 1..1024.
- `RESET_DATA`, default all zeros: value of every payload register after reset. Set it per instance, for example a reset PC of 0x3000_0000 in the PC field.
- `SKID`, default 1: 1 selects a two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.

Ports:
- `clk` in 1: clock. All state changes happen on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: the producer offers `in_data`.
- `in_ready` out 1: the stage can accept this cycle.
- `in_data` in DATA_W: payload from the producer.
- `out_valid` out 1: `out_data` holds a live entry.
- `out_ready` in 1: the consumer takes `out_data` this cycle.
- `out_data` out DATA_W: payload to the consumer.
- `count` out 2: number of held entries, 0..2 (0..1 when SKID=0).

## Operation
- Fire rules:
  - Accept = `in_valid & in_ready`.
  - Drain = `out_valid & out_ready`.
- Storage:
  - Main slot M drives `out_data`.
  - Skid slot S exists only when SKID=1.
- States: EMPTY (count 0), ONE (M valid), FULL (M and S valid; SKID=1 only).
- Transitions for SKID=1, in priority order:
  - `flush`=1 → EMPTY. Any accept in that cycle is dropped. Payload registers keep their values.
  - EMPTY, accept → M←in, go to ONE.
  - ONE, accept & drain → M←in, stay in ONE.
  - ONE, accept & !drain → S←in, go to FULL.
  - ONE, !accept & drain → EMPTY.
  - FULL, drain → M←S, go to ONE. No accept is possible because `in_ready`=0.
  - All other cases: hold state and payload.
- `in_ready` for SKID=1: a register, equal to (next state != FULL).
- SKID=0:
  - `in_ready` = !out_valid | out_ready (combinational).
  - Only EMPTY and ONE exist.
  - accept & drain → M←in, stay in ONE.
- `flush` dominates both accept and drain. During a flush cycle the producer must treat its offer as consumed.
- `out_data` when `out_valid`=0: holds the last M value. Consumers must ignore it.

## Timing
- Reset values: `out_valid`=0, `count`=0, state EMPTY, M and S = RESET_DATA, `in_ready`=1 (for SKID=0 this follows from `out_valid`=0).
- Reset release: the first accept can occur on the first rising edge after `rst` deasserts.
- Reset asserted mid-operation: all entries are lost immediately (asynchronous), with no partial transfer.
- Latency: 1 cycle from accept to `out_valid`. No bypass from `in_data` to `out_data`.
- Throughput: 1 transfer per cycle in steady state under both SKID settings.
- Combinational paths:
  - `out_valid`, `out_data` and `count` come only from registers.
  - With SKID=1, `in_ready` also comes only from a register.
  - With SKID=0, the only combinational path is `out_ready` → `in_ready`.
- Handshake rules:
  - Once `out_valid`=1, `out_valid` and `out_data` stay stable until drain or flush.
  - The producer may not retract `in_valid` before it is accepted, except on `flush`.
- FULL: `in_ready`=0 is driven in the same cycle that `count`=2.

## Structure
- Package `ysyx_041461_pipe_pkg`:
  - State encodings: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - Per-stage payload width constants so that the stage instances and their pack/unpack logic agree.
- Sub-module `ysyx_041461_pipe_slot`:
  - One DATA_W register with async active-low reset to RESET_DATA and a load enable.
  - Instantiated once for M and, under a SKID=1 generate, once for S.

## Test plan
- Reset: `rst`=0 mid-stream with count=2 → `out_valid`=0, `count`=0, `out_data`=RESET_DATA, `in_ready`=1, all immediately. First accept after release appears on `out_data` one cycle later.
- Streaming (SKID=1, DATA_W=64):
  - Stimulus: `in_valid`=1 with values 1,2,3,…,100 and `out_ready`=1 throughout.
  - Required: outputs 1..100 in order, one per cycle, after 1 cycle of latency; `count` stays 1.
- Back-pressure:
  - Stimulus: `out_ready`=0 while 0xA then 0xB are offered.
  - Required: `count`=2 and `in_ready`=0; 0xC is held by the producer. After `out_ready`=1, the output sequence is 0xA, 0xB, 0xC with no loss or duplication.
- Flush:
  - Stimulus: count=2 with 0x11 and 0x22 held; `flush`=1 together with `in_valid`=1 carrying 0x33.
  - Required: next cycle `out_valid`=0 and `count`=0; 0x33 is never output.
- SKID=0 same-cycle drain and accept: with M=5, `out_ready`=1 and `in_valid` carrying 6 → `in_ready`=1 combinationally, next cycle `out_data`=6 and `count`=1.
- Random soak: random `in_valid`, `out_ready` and `flush`, run against a queue scoreboard → no drop, no duplicate, in order, `out_data` stable while stalled.
